// File: rtl/cache_pkg.sv
// Shared types and helpers for the N-way set-associative cache and its replacement logic.
package cache_pkg;

   typedef enum logic {
      REPL_LRU,
      REPL_FIFO
   } repl_policy_e;

   typedef enum logic [1:0] {
      IDLE,
      SWAP_OUT,
      SWAP_IN,
      SWAP_IN_OK
   } cache_state_e;

   localparam int WORD_W = 32;

   // Width of a way index; a direct-mapped cache still needs a one-bit field.
   function automatic int way_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/cache_repl.sv
// Replacement state for every set: LRU ranks per way and a FIFO round-robin pointer.
// Produces the victim way for the queried set, preferring the lowest invalid way.
module cache_repl
   import cache_pkg::*;
#(
   parameter int           SET_ADDR_LEN = 3,
   parameter int           WAY_CNT      = 4,
   parameter repl_policy_e REPL_POLICY  = REPL_LRU,
   localparam int          SETS         = 1 << SET_ADDR_LEN,
   localparam int          WAY_W        = way_bits(WAY_CNT)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SET_ADDR_LEN-1:0] query_set,
   input  logic [WAY_CNT-1:0]      query_valid,
   output logic [WAY_W-1:0]        victim,
   output logic                    set_full,
   input  logic                    upd_en,
   input  logic [SET_ADDR_LEN-1:0] upd_set,
   input  logic [WAY_W-1:0]        upd_way,
   input  logic                    fifo_adv
);

   logic [WAY_W-1:0] rank     [SETS][WAY_CNT];
   logic [WAY_W-1:0] fifo_ptr [SETS];
   logic             found;

   assign set_full = &query_valid;

   // Victim choice: a free way wins; a full set falls back to the configured policy.
   always_comb begin
      victim = '0;
      found  = 1'b0;
      for (int w = 0; w < WAY_CNT; w++) begin
         if (!query_valid[w] && !found) begin
            victim = WAY_W'(w);
            found  = 1'b1;
         end
      end
      if (!found) begin
         if (REPL_POLICY == REPL_FIFO) begin
            victim = fifo_ptr[query_set];
         end else begin
            for (int w = 0; w < WAY_CNT; w++) begin
               if (rank[query_set][w] == '0) begin
                  victim = WAY_W'(w);
               end
            end
         end
      end
   end

   // Accessed way becomes most recent; ways above its old rank slide down by one,
   // so ranks stay a permutation.  The FIFO pointer only moves on fills into full sets.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAY_CNT; w++) begin
               rank[s][w] <= WAY_W'(w);
            end
            fifo_ptr[s] <= '0;
         end
      end else begin
         if (upd_en) begin
            for (int w = 0; w < WAY_CNT; w++) begin
               if (WAY_W'(w) == upd_way) begin
                  rank[upd_set][w] <= WAY_W'(WAY_CNT - 1);
               end else if (rank[upd_set][w] > rank[upd_set][upd_way]) begin
                  rank[upd_set][w] <= rank[upd_set][w] - WAY_W'(1);
               end
            end
         end
         if (fifo_adv) begin
            fifo_ptr[upd_set] <= WAY_W'((int'(fifo_ptr[upd_set]) + 1) % WAY_CNT);
         end
      end
   end

endmodule

// File: rtl/main_mem.sv
// Line-oriented main memory model with a fixed-latency request/grant handshake.
// Lines never written since reset read back a pattern derived from their address.
module main_mem #(
   parameter int ADDR_W     = 10,
   parameter int LINE_WORDS = 8,
   parameter int LATENCY    = 3,
   localparam int LINE_W    = 32 * LINE_WORDS,
   localparam int DEPTH     = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd_req,
   input  logic              wr_req,
   input  logic [LINE_W-1:0] wr_line,
   output logic [LINE_W-1:0] rd_line,
   output logic              gnt
);

   logic [LINE_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  written;
   logic [7:0]        wait_cnt;
   logic [LINE_W-1:0] dflt_line;

   assign gnt = (rd_req | wr_req) && (wait_cnt == 8'(LATENCY));

   // Count cycles a request has been pending; restart once it is granted or dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (!(rd_req | wr_req) || gnt) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   // Remember which lines hold written data rather than the address pattern.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         written <= '0;
      end else if (wr_req && gnt) begin
         written[addr] <= 1'b1;
      end
   end

   // Line storage itself is never cleared.
   always_ff @(posedge clk) begin
      if (wr_req && gnt) begin
         mem[addr] <= wr_line;
      end
   end

   // Read path: stored line if written, otherwise the address-derived pattern.
   always_comb begin
      dflt_line = '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
         dflt_line[i*32 +: 32] = 32'hA500_0000 | (32'(addr) << 4) | 32'(i);
      end
      rd_line = written[addr] ? mem[addr] : dflt_line;
   end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back cache with write-allocate, backed by main_mem.
// Hits are serviced in one cycle from IDLE; misses write back a dirty victim, then refill.
module cache_nway
   import cache_pkg::*;
#(
   parameter int           LINE_ADDR_LEN = 3,
   parameter int           SET_ADDR_LEN  = 3,
   parameter int           TAG_ADDR_LEN  = 7,
   parameter int           WAY_CNT       = 4,
   parameter repl_policy_e REPL_POLICY   = REPL_LRU,
   parameter int           MEM_LATENCY   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        rd_req,
   input  logic        wr_req,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        miss,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int SETS       = 1 << SET_ADDR_LEN;
   localparam int LINE_WORDS = 1 << LINE_ADDR_LEN;
   localparam int LINE_W     = WORD_W * LINE_WORDS;
   localparam int WAY_W      = way_bits(WAY_CNT);
   localparam int MEM_ADDR_W = TAG_ADDR_LEN + SET_ADDR_LEN;
   localparam int ADDR_USED  = 2 + LINE_ADDR_LEN + SET_ADDR_LEN + TAG_ADDR_LEN;

   cache_state_e state;

   logic [LINE_W-1:0]       line_data [SETS][WAY_CNT];
   logic [TAG_ADDR_LEN-1:0] line_tag  [SETS][WAY_CNT];
   logic [WAY_CNT-1:0]      valid     [SETS];
   logic [WAY_CNT-1:0]      dirty     [SETS];

   logic [LINE_ADDR_LEN-1:0] req_word;
   logic [SET_ADDR_LEN-1:0]  req_set;
   logic [TAG_ADDR_LEN-1:0]  req_tag;
   logic                     req;
   logic                     hit;
   logic [WAY_W-1:0]         hit_way;
   logic [31:0]              hit_word;

   logic [WAY_W-1:0]         victim;
   logic                     set_full;
   logic [WAY_W-1:0]         vict_way;
   logic [SET_ADDR_LEN-1:0]  vict_set;
   logic [TAG_ADDR_LEN-1:0]  vict_tag;
   logic                     vict_full;

   logic                     upd_en;
   logic [SET_ADDR_LEN-1:0]  upd_set;
   logic [WAY_W-1:0]         upd_way;
   logic                     fifo_adv;

   logic [MEM_ADDR_W-1:0]    mem_addr;
   logic                     mem_rd_req;
   logic                     mem_wr_req;
   logic [LINE_W-1:0]        mem_wr_line;
   logic [LINE_W-1:0]        mem_rd_line;
   logic                     mem_gnt;
   logic [LINE_W-1:0]        fill_line;

   logic                     unused_addr_bits;

   assign req_word = addr[LINE_ADDR_LEN+1 : 2];
   assign req_set  = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1 : LINE_ADDR_LEN+2];
   assign req_tag  = addr[ADDR_USED-1 : LINE_ADDR_LEN+SET_ADDR_LEN+2];
   assign unused_addr_bits = ^{addr[31:ADDR_USED], addr[1:0]};

   assign req      = rd_req | wr_req;
   assign miss     = req & ~(hit & (state == IDLE));
   assign hit_word = line_data[req_set][hit_way][{req_word, 5'b0} +: 32];

   // Tag lookup across the addressed set; scanning downwards lets the lowest match win.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = WAY_CNT - 1; w >= 0; w--) begin
         if (valid[req_set][w] && (line_tag[req_set][w] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // Replacement state moves on a serviced hit and again when a refill lands.
   always_comb begin
      upd_en   = 1'b0;
      upd_set  = req_set;
      upd_way  = hit_way;
      fifo_adv = 1'b0;
      if (state == SWAP_IN_OK) begin
         upd_en   = 1'b1;
         upd_set  = vict_set;
         upd_way  = vict_way;
         fifo_adv = vict_full;
      end else if (state == IDLE && req && hit) begin
         upd_en = 1'b1;
      end
   end

   cache_repl #(
      .SET_ADDR_LEN (SET_ADDR_LEN),
      .WAY_CNT      (WAY_CNT),
      .REPL_POLICY  (REPL_POLICY)
   ) u_repl (
      .clk         (clk),
      .rst         (rst),
      .query_set   (req_set),
      .query_valid (valid[req_set]),
      .victim      (victim),
      .set_full    (set_full),
      .upd_en      (upd_en),
      .upd_set     (upd_set),
      .upd_way     (upd_way),
      .fifo_adv    (fifo_adv)
   );

   main_mem #(
      .ADDR_W     (MEM_ADDR_W),
      .LINE_WORDS (LINE_WORDS),
      .LATENCY    (MEM_LATENCY)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .addr    (mem_addr),
      .rd_req  (mem_rd_req),
      .wr_req  (mem_wr_req),
      .wr_line (mem_wr_line),
      .rd_line (mem_rd_line),
      .gnt     (mem_gnt)
   );

   // Line data and tags are not cleared by reset; the valid bits guard them.
   always_ff @(posedge clk) begin
      if (state == IDLE && hit && wr_req && !rd_req) begin
         line_data[req_set][hit_way][{req_word, 5'b0} +: 32] <= wr_data;
      end
      if (state == SWAP_IN_OK) begin
         line_data[vict_set][vict_way] <= fill_line;
         line_tag[vict_set][vict_way]  <= vict_tag;
      end
   end

   // Controller: services hits from IDLE and walks a miss through write-back and refill.
   // The victim is frozen at the miss so later address changes cannot redirect the fill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rd_data     <= '0;
         hit_count   <= '0;
         miss_count  <= '0;
         mem_rd_req  <= 1'b0;
         mem_wr_req  <= 1'b0;
         mem_addr    <= '0;
         mem_wr_line <= '0;
         fill_line   <= '0;
         vict_way    <= '0;
         vict_set    <= '0;
         vict_tag    <= '0;
         vict_full   <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            dirty[s] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (req && hit) begin
                  if (hit_count != '1) begin
                     hit_count <= hit_count + 32'd1;
                  end
                  if (rd_req) begin
                     rd_data <= hit_word;
                  end else begin
                     dirty[req_set][hit_way] <= 1'b1;
                  end
               end else if (req) begin
                  if (miss_count != '1) begin
                     miss_count <= miss_count + 32'd1;
                  end
                  vict_way  <= victim;
                  vict_set  <= req_set;
                  vict_tag  <= req_tag;
                  vict_full <= set_full;
                  if (valid[req_set][victim] && dirty[req_set][victim]) begin
                     mem_wr_line <= line_data[req_set][victim];
                     mem_addr    <= {line_tag[req_set][victim], req_set};
                     mem_wr_req  <= 1'b1;
                     state       <= SWAP_OUT;
                  end else begin
                     mem_addr   <= {req_tag, req_set};
                     mem_rd_req <= 1'b1;
                     state      <= SWAP_IN;
                  end
               end
            end
            SWAP_OUT: begin
               if (mem_gnt) begin
                  mem_wr_req <= 1'b0;
                  mem_rd_req <= 1'b1;
                  mem_addr   <= {vict_tag, vict_set};
                  state      <= SWAP_IN;
               end
            end
            SWAP_IN: begin
               if (mem_gnt) begin
                  mem_rd_req <= 1'b0;
                  fill_line  <= mem_rd_line;
                  state      <= SWAP_IN_OK;
               end
            end
            SWAP_IN_OK: begin
               valid[vict_set][vict_way] <= 1'b1;
               dirty[vict_set][vict_way] <= 1'b0;
               state                     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_nway.sv
// Self-checking bench for cache_nway: directed scenarios plus random traffic on an LRU
// and a FIFO instance, compared against a behavioural model of cache and memory.
module tb_cache_nway;
   import cache_pkg::*;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic        rd_l, wr_l, rd_f, wr_f;
   logic [31:0] rd_data_l, rd_data_f, hits_l, hits_f, misses_l, misses_f;
   logic        miss_l, miss_f;
   bit          sel;

   logic        obs_miss, obs_mem_wr, obs_mem_rd;
   logic [31:0] obs_rd_data, obs_hits, obs_misses;
   logic [9:0]  obs_mem_addr;

   int errors = 0;
   int checks = 0;

   // Model state: per-set ways with last-use stamps, FIFO pointers and a sparse memory.
   bit          mvalid [8][4];
   bit          mdirty [8][4];
   int unsigned mtag   [8][4];
   logic [31:0] mdata  [8][4][8];
   int unsigned stamp  [8][4];
   int unsigned fptr   [8];
   int unsigned now_t;
   logic [31:0] memw   [int unsigned];
   logic [31:0] m_hits, m_misses, exp_rd;
   int unsigned exp_cycles;
   bit          exp_wb;
   logic [31:0] exp_wb_addr;

   always #5 clk = ~clk;

   cache_nway #(.REPL_POLICY(REPL_LRU), .MEM_LATENCY(LAT)) dut_lru (
      .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_l), .wr_req(wr_l), .wr_data(wr_data),
      .rd_data(rd_data_l), .miss(miss_l), .hit_count(hits_l), .miss_count(misses_l)
   );

   cache_nway #(.REPL_POLICY(REPL_FIFO), .MEM_LATENCY(LAT)) dut_fifo (
      .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_f), .wr_req(wr_f), .wr_data(wr_data),
      .rd_data(rd_data_f), .miss(miss_f), .hit_count(hits_f), .miss_count(misses_f)
   );

   assign obs_miss     = sel ? miss_f : miss_l;
   assign obs_rd_data  = sel ? rd_data_f : rd_data_l;
   assign obs_hits     = sel ? hits_f : hits_l;
   assign obs_misses   = sel ? misses_f : misses_l;
   assign obs_mem_wr   = sel ? dut_fifo.mem_wr_req : dut_lru.mem_wr_req;
   assign obs_mem_rd   = sel ? dut_fifo.mem_rd_req : dut_lru.mem_rd_req;
   assign obs_mem_addr = sel ? dut_fifo.mem_addr : dut_lru.mem_addr;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, expv);
      end
   endtask

   function automatic logic [31:0] memRead(input int unsigned waddr);
      if (memw.exists(waddr)) return memw[waddr];
      return 32'hA500_0000 | ((waddr >> 3) << 4) | (waddr & 7);
   endfunction

   task automatic modelReset();
      for (int s = 0; s < 8; s++) begin
         for (int w = 0; w < 4; w++) begin
            mvalid[s][w] = 0;
            mdirty[s][w] = 0;
            stamp[s][w]  = w;
         end
         fptr[s] = 0;
      end
      now_t = 4;
      memw.delete();
      m_hits = 0;
      m_misses = 0;
      exp_rd = 0;
   endtask

   task automatic modelAccess(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] wd);
      int unsigned word, set, tag;
      int way, victim;
      word = (a >> 2) & 7;
      set  = (a >> 5) & 7;
      tag  = (a >> 8) & 127;
      way = -1;
      exp_wb = 0;
      exp_wb_addr = 0;
      exp_cycles = 0;
      for (int w = 0; w < 4; w++)
         if (way < 0 && mvalid[set][w] && mtag[set][w] == tag) way = w;
      if (way < 0) begin
         m_misses++;
         victim = -1;
         for (int w = 0; w < 4; w++)
            if (victim < 0 && !mvalid[set][w]) victim = w;
         if (victim < 0) begin
            if (sel) begin
               victim = fptr[set];
               fptr[set] = (fptr[set] + 1) % 4;
            end else begin
               victim = 0;
               for (int w = 1; w < 4; w++)
                  if (stamp[set][w] < stamp[set][victim]) victim = w;
            end
         end
         exp_cycles = 1 + (LAT + 1) + 1;
         if (mvalid[set][victim] && mdirty[set][victim]) begin
            exp_wb = 1;
            exp_wb_addr = (mtag[set][victim] << 3) | set;
            exp_cycles += LAT + 1;
            for (int i = 0; i < 8; i++)
               memw[(((mtag[set][victim] << 3) | set) << 3) + i] = mdata[set][victim][i];
         end
         for (int i = 0; i < 8; i++)
            mdata[set][victim][i] = memRead((((tag << 3) | set) << 3) + i);
         mtag[set][victim] = tag;
         mvalid[set][victim] = 1;
         mdirty[set][victim] = 0;
         way = victim;
      end
      stamp[set][way] = now_t++;
      m_hits++;
      if (rd) exp_rd = mdata[set][way][word];
      else if (wr) begin
         mdata[set][way][word] = wd;
         mdirty[set][way] = 1;
      end
   endtask

   task automatic driveReq(input bit rd, input bit wr);
      rd_l = sel ? 1'b0 : rd;
      wr_l = sel ? 1'b0 : wr;
      rd_f = sel ? rd : 1'b0;
      wr_f = sel ? wr : 1'b0;
   endtask

   task automatic resetAll();
      @(negedge clk);
      driveReq(0, 0);
      rst = 1'b1;
      #1;
      checkOutput("rst_rd_data", obs_rd_data, 32'h0);
      checkOutput("rst_hits", obs_hits, 32'h0);
      checkOutput("rst_misses", obs_misses, 32'h0);
      checkOutput("rst_miss", {31'b0, obs_miss}, 32'h0);
      modelReset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] a, input bit rd, input bit wr,
                                input logic [31:0] wd, output int cycles);
      bit seen_wb;
      logic [31:0] wb_addr;
      modelAccess(a, rd, wr, wd);
      @(negedge clk);
      addr = a;
      wr_data = wd;
      driveReq(rd, wr);
      cycles = 0;
      seen_wb = 0;
      wb_addr = 0;
      #1;
      while (obs_miss === 1'b1 && cycles < 100) begin
         cycles++;
         @(negedge clk);
         #1;
         if (obs_mem_wr === 1'b1 && !seen_wb) begin
            seen_wb = 1;
            wb_addr = 32'(obs_mem_addr);
         end
      end
      @(negedge clk);
      driveReq(0, 0);
      #1;
      checkOutput("miss_cycles", cycles, exp_cycles);
      checkOutput("rd_data", obs_rd_data, exp_rd);
      checkOutput("hit_count", obs_hits, m_hits);
      checkOutput("miss_count", obs_misses, m_misses);
      checkOutput("writeback", {31'b0, seen_wb}, {31'b0, exp_wb});
      if (exp_wb) checkOutput("wb_addr", wb_addr, exp_wb_addr);
   endtask

   initial begin
      int cyc;
      logic [31:0] a;
      int op;
      rst = 1'b1;
      addr = 0;
      wr_data = 0;
      sel = 0;
      driveReq(0, 0);
      #1;
      checkOutput("init_lru_rd_data", rd_data_l, 32'h0);
      checkOutput("init_fifo_hits", hits_f, 32'h0);
      modelReset();
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] cold read");
      applyStimulus(32'h000, 1, 0, 0, cyc);
      checkOutput("cold_data", obs_rd_data, 32'hA500_0000);
      checkOutput("cold_misses", obs_misses, 32'd1);
      checkOutput("cold_hits", obs_hits, 32'd1);

      $display("[TB] replacement order");
      for (int p = 0; p < 2; p++) begin
         sel = p[0];
         resetAll();
         applyStimulus(32'h000, 1, 0, 0, cyc);
         applyStimulus(32'h100, 1, 0, 0, cyc);
         applyStimulus(32'h200, 1, 0, 0, cyc);
         applyStimulus(32'h300, 1, 0, 0, cyc);
         applyStimulus(32'h000, 1, 0, 0, cyc);
         applyStimulus(32'h400, 1, 0, 0, cyc);
         applyStimulus(32'h000, 1, 0, 0, cyc);
         checkOutput(sel ? "fifo_000_evicted" : "lru_000_kept", cyc, sel ? 6 : 0);
      end
      sel = 0;

      $display("[TB] dirty write-back");
      resetAll();
      applyStimulus(32'h004, 0, 1, 32'hDEADBEEF, cyc);
      applyStimulus(32'h100, 1, 0, 0, cyc);
      applyStimulus(32'h200, 1, 0, 0, cyc);
      applyStimulus(32'h300, 1, 0, 0, cyc);
      applyStimulus(32'h400, 1, 0, 0, cyc);
      checkOutput("wb_cycles", cyc, 10);
      applyStimulus(32'h004, 1, 0, 0, cyc);
      checkOutput("wb_reread", obs_rd_data, 32'hDEADBEEF);

      $display("[TB] simultaneous read and write");
      resetAll();
      applyStimulus(32'h008, 1, 0, 0, cyc);
      applyStimulus(32'h008, 1, 1, 32'h12345678, cyc);
      checkOutput("rdwr_old", obs_rd_data, 32'hA500_0002);
      applyStimulus(32'h100, 1, 0, 0, cyc);
      applyStimulus(32'h200, 1, 0, 0, cyc);
      applyStimulus(32'h300, 1, 0, 0, cyc);
      applyStimulus(32'h400, 1, 0, 0, cyc);
      checkOutput("rdwr_clean_evict", cyc, 6);
      applyStimulus(32'h008, 1, 0, 0, cyc);
      checkOutput("rdwr_reread", obs_rd_data, 32'hA500_0002);

      $display("[TB] reset during refill");
      resetAll();
      applyStimulus(32'h000, 1, 0, 0, cyc);
      @(negedge clk);
      addr = 32'h100;
      driveReq(1, 0);
      cyc = 0;
      #1;
      while (obs_mem_rd !== 1'b1 && cyc < 20) begin
         cyc++;
         @(negedge clk);
         #1;
      end
      checkOutput("swapin_reached", {31'b0, obs_mem_rd}, 32'h1);
      #2;
      rst = 1'b1;
      driveReq(0, 0);
      #1;
      checkOutput("midrst_mem_rd", {31'b0, obs_mem_rd}, 32'h0);
      checkOutput("midrst_hits", obs_hits, 32'h0);
      checkOutput("midrst_misses", obs_misses, 32'h0);
      modelReset();
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(32'h000, 1, 0, 0, cyc);
      checkOutput("midrst_remiss", cyc, 6);

      $display("[TB] random traffic");
      for (int p = 0; p < 2; p++) begin
         sel = p[0];
         resetAll();
         repeat (150) begin
            a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 1) << 5) | ($urandom_range(0, 7) << 2);
            op = $urandom_range(0, 3);
            applyStimulus(a, op != 2, op >= 2, $urandom, cyc);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
